core_id_ex_stage: RTL
=====================

// Module: core_id_ex_stage
// PURPOSE
//  ID->EX pipeline register of the RV32I core; directly feeds the combinational ALU with opcode/funct7/funct3/num1u/num2u/immu.
//  Resolves RAW hazards by forwarding at capture time from EX (ALU result fed back), MEM and WB.
//  Detects load-use hazards, stalls ID and inserts a bubble. Supports branch flush and downstream hold.
//  Counts inserted bubbles for performance monitoring.
// PARAMETERS
//  BCNT_W   16   width of saturating bubble counter
// PORTS
//  clk           in   1   core clock, all state on rising edge
//  rst_n         in   1   asynchronous active-low reset
//  i_valid       in   1   ID holds a valid decoded instruction
//  i_pc          in   32  PC of ID instruction
//  i_opcode      in   7   decoded opcode
//  i_funct7      in   7   decoded funct7
//  i_funct3      in   3   decoded funct3
//  i_rs1,i_rs2   in   5   source register indices
//  i_rd          in   5   destination register index
//  i_rdata1      in   32  regfile read data for rs1
//  i_rdata2      in   32  regfile read data for rs2
//  i_imm         in   32  sign-extended immediate
//  i_ex_res      in   32  ALU result of instruction currently on this stage's outputs
//  i_mem_rd      in   5   MEM-stage dest (0 = no write)
//  i_mem_wdata   in   32  MEM-stage final writeback value
//  i_wb_rd       in   5   WB-stage dest (0 = no write)
//  i_wb_wdata    in   32  WB-stage writeback value
//  i_flush       in   1   branch/jump redirect: kill ID instruction
//  i_ex_hold     in   1   downstream stall: hold outputs
//  o_valid       out  1   EX instruction valid
//  o_pc          out  32  EX PC
//  o_opcode      out  7   to ALU i_opcode
//  o_funct7      out  7   to ALU i_funct7
//  o_funct3      out  3   to ALU i_funct3
//  o_num1u       out  32  forwarded rs1 value, to ALU
//  o_num2u       out  32  forwarded rs2 value, to ALU
//  o_immu        out  32  immediate, to ALU
//  o_rd          out  5   EX destination
//  o_stall_id    out  1   combinational: ID/IF must hold
//  o_bubble_cnt  out  BCNT_W  saturating count of load-use bubbles
// BEHAVIOUR
//  Reset (async, rst_n=0): all registered outputs 0 (opcode 0 => ALU yields 0 => NOP); bubble_cnt 0.
//  rs1 used unless opcode in {0110111 LUI, 0010111 AUIPC, 1101111 JAL}.
//  rs2 used only for {0110011 OP, 0100011 STORE, 1100011 BRANCH}.
//  load_use = o_valid & o_opcode==0000011 & o_rd!=0 & i_valid & ((rs1 used & i_rs1==o_rd) | (rs2 used & i_rs2==o_rd)).
//  o_stall_id = (load_use & ~i_flush) | i_ex_hold.
//  Per-edge priority, highest first:
//   1 i_flush: o_valid<=0, opcode/funct/rd<=0; overrides hold and load_use.
//   2 i_ex_hold: all outputs hold; no capture, no bubble, counter unchanged.
//   3 load_use: bubble (o_valid<=0, opcode/rd<=0); bubble_cnt+=1, saturates at all-ones.
//   4 else capture i_* fields; o_valid<=i_valid; if i_valid=0 store NOP (opcode 0, rd 0).
//  Forward mux per operand (rs1->num1u, rs2->num2u), index 0 never forwarded (value 0):
//   o_valid & o_rd==rs & o_opcode!=LOAD -> i_ex_res; else i_mem_rd==rs -> i_mem_wdata;
//   else i_wb_rd==rs -> i_wb_wdata; else i_rdataN.
//  Unused operand captured as regfile value (don't-care downstream).
//  Latency: 1 cycle ID->EX; forwarded value sampled at capture edge only.
//  Reset mid-operation: immediate clear, no partial state retained.
// TESTING
//  T1 reset: rst_n low mid-cycle -> all outputs 0 within same cycle, bubble_cnt 0.
//  T2 EX forward: ADD x5 in EX, i_ex_res=0x10; ID ADD x6,x5,x5 -> o_num1u=o_num2u=0x10.
//  T3 priority: x7 in MEM=0xAA and WB=0xBB, ID uses x7 -> num1u=0xAA; x0 source -> 0 despite rd=0 traffic.
//  T4 load-use: LW x8 in EX, ID ADDI x9,x8,1 -> o_stall_id=1, bubble next edge, bubble_cnt=1; next cycle x8 via MEM.
//  T5 flush+hold: i_flush=1,i_ex_hold=1 same edge -> o_valid=0; hold alone -> outputs unchanged 3 cycles.
//  T6 saturation: BCNT_W=2, 5 load-use bubbles -> bubble_cnt=3.

Source files
------------

// File: rtl/core_id_ex_stage.sv
// ID->EX pipeline register for the RV32I core: operand forwarding at capture,
// load-use bubble insertion, branch flush, downstream hold and a bubble counter.
module core_id_ex_stage #(
    parameter int BCNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_valid,
    input  logic [31:0]       i_pc,
    input  logic [6:0]        i_opcode,
    input  logic [6:0]        i_funct7,
    input  logic [2:0]        i_funct3,
    input  logic [4:0]        i_rs1,
    input  logic [4:0]        i_rs2,
    input  logic [4:0]        i_rd,
    input  logic [31:0]       i_rdata1,
    input  logic [31:0]       i_rdata2,
    input  logic [31:0]       i_imm,
    input  logic [31:0]       i_ex_res,
    input  logic [4:0]        i_mem_rd,
    input  logic [31:0]       i_mem_wdata,
    input  logic [4:0]        i_wb_rd,
    input  logic [31:0]       i_wb_wdata,
    input  logic              i_flush,
    input  logic              i_ex_hold,
    output logic              o_valid,
    output logic [31:0]       o_pc,
    output logic [6:0]        o_opcode,
    output logic [6:0]        o_funct7,
    output logic [2:0]        o_funct3,
    output logic [31:0]       o_num1u,
    output logic [31:0]       o_num2u,
    output logic [31:0]       o_immu,
    output logic [4:0]        o_rd,
    output logic              o_stall_id,
    output logic [BCNT_W-1:0] o_bubble_cnt
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;

    function automatic logic uses_rs1(input logic [6:0] op);
        return !((op == OPC_LUI) || (op == OPC_AUIPC) || (op == OPC_JAL));
    endfunction

    function automatic logic uses_rs2(input logic [6:0] op);
        return (op == OPC_OP) || (op == OPC_STORE) || (op == OPC_BRANCH);
    endfunction

    // A loaded value is not yet in i_ex_res, so EX forwarding is disabled for loads.
    function automatic logic [31:0] fwd_sel(
        input logic [4:0]  rs,
        input logic [31:0] rdata,
        input logic        ex_ok,
        input logic [4:0]  ex_rd,
        input logic [31:0] ex_res,
        input logic [4:0]  mem_rd,
        input logic [31:0] mem_wdata,
        input logic [4:0]  wb_rd,
        input logic [31:0] wb_wdata
    );
        logic [31:0] v;
        if (rs == 5'd0) begin
            v = 32'd0;
        end else if (ex_ok && (ex_rd == rs)) begin
            v = ex_res;
        end else if (mem_rd == rs) begin
            v = mem_wdata;
        end else if (wb_rd == rs) begin
            v = wb_wdata;
        end else begin
            v = rdata;
        end
        return v;
    endfunction

    logic              valid_r;
    logic [31:0]       pc_r;
    logic [6:0]        opcode_r;
    logic [6:0]        funct7_r;
    logic [2:0]        funct3_r;
    logic [31:0]       num1_r;
    logic [31:0]       num2_r;
    logic [31:0]       imm_r;
    logic [4:0]        rd_r;
    logic [BCNT_W-1:0] bcnt_r;

    logic              load_use_s;
    logic              ex_fwd_ok_s;
    logic [31:0]       fwd1_s;
    logic [31:0]       fwd2_s;

    // Hazard detection and forwarded operand selection for the ID instruction.
    always_comb begin
        load_use_s  = 1'b0;
        ex_fwd_ok_s = valid_r && (opcode_r != OPC_LOAD);
        if (valid_r && (opcode_r == OPC_LOAD) && (rd_r != 5'd0) && i_valid) begin
            load_use_s = (uses_rs1(i_opcode) && (i_rs1 == rd_r)) ||
                         (uses_rs2(i_opcode) && (i_rs2 == rd_r));
        end else begin
            load_use_s = 1'b0;
        end
        fwd1_s = fwd_sel(i_rs1, i_rdata1, ex_fwd_ok_s, rd_r, i_ex_res,
                         i_mem_rd, i_mem_wdata, i_wb_rd, i_wb_wdata);
        fwd2_s = fwd_sel(i_rs2, i_rdata2, ex_fwd_ok_s, rd_r, i_ex_res,
                         i_mem_rd, i_mem_wdata, i_wb_rd, i_wb_wdata);
    end

    // Pipeline register: flush beats hold, hold beats load-use bubble, then capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r  <= 1'b0;
            pc_r     <= 32'd0;
            opcode_r <= 7'd0;
            funct7_r <= 7'd0;
            funct3_r <= 3'd0;
            num1_r   <= 32'd0;
            num2_r   <= 32'd0;
            imm_r    <= 32'd0;
            rd_r     <= 5'd0;
        end else if (i_flush) begin
            valid_r  <= 1'b0;
            opcode_r <= 7'd0;
            funct7_r <= 7'd0;
            funct3_r <= 3'd0;
            rd_r     <= 5'd0;
        end else if (!i_ex_hold) begin
            if (load_use_s) begin
                valid_r  <= 1'b0;
                opcode_r <= 7'd0;
                funct7_r <= 7'd0;
                funct3_r <= 3'd0;
                rd_r     <= 5'd0;
            end else begin
                valid_r  <= i_valid;
                pc_r     <= i_pc;
                opcode_r <= i_valid ? i_opcode : 7'd0;
                funct7_r <= i_funct7;
                funct3_r <= i_funct3;
                num1_r   <= fwd1_s;
                num2_r   <= fwd2_s;
                imm_r    <= i_imm;
                rd_r     <= i_valid ? i_rd : 5'd0;
            end
        end
    end

    // Saturating count of inserted load-use bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcnt_r <= {BCNT_W{1'b0}};
        end else if (!i_flush && !i_ex_hold && load_use_s && !(&bcnt_r)) begin
            bcnt_r <= bcnt_r + {{(BCNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign o_valid      = valid_r;
    assign o_pc         = pc_r;
    assign o_opcode     = opcode_r;
    assign o_funct7     = funct7_r;
    assign o_funct3     = funct3_r;
    assign o_num1u      = num1_r;
    assign o_num2u      = num2_r;
    assign o_immu       = imm_r;
    assign o_rd         = rd_r;
    assign o_stall_id   = (load_use_s && !i_flush) || i_ex_hold;
    assign o_bubble_cnt = bcnt_r;

endmodule
